// File: rtl/wb_arb_pkg.sv
// Shared constants and the write-request record for the dual-lane write-back arbiter.
package wb_arb_pkg;
    localparam int DEPTH    = 4;
    localparam int STALL_TH = DEPTH - 1;
    localparam int REG_AW   = 5;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } wr_req_t;
endpackage

// File: rtl/wb_pending_fifo.sv
// Pending-write queue: up to two pushes and one pop per cycle, with address-match lookups.
module wb_pending_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = wb_arb_pkg::DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pop,
    input  logic                         push0,
    input  logic [REG_AW-1:0]            push0_rd,
    input  logic [XLEN-1:0]              push0_wd,
    input  logic                         push1,
    input  logic [REG_AW-1:0]            push1_rd,
    input  logic [XLEN-1:0]              push1_wd,
    output logic [REG_AW-1:0]            head_rd,
    output logic [XLEN-1:0]              head_wd,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [REG_AW-1:0]            lk_addr_a,
    input  logic [REG_AW-1:0]            lk_addr_b,
    output logic                         match_a,
    output logic                         match_b
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wr_req_t       mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign head_rd = mem[rd_ptr].rd;
    assign head_wd = mem[rd_ptr].wd;

    // The we field doubles as the entry-valid bit; a same-slot push after a pop wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop) begin
                mem[rd_ptr].we <= 1'b0;
                rd_ptr         <= ptr_inc(rd_ptr);
            end
            if (push0) mem[wr_ptr] <= '{we: 1'b1, rd: push0_rd, wd: push0_wd};
            if (push1) mem[ptr_inc(wr_ptr)] <= '{we: 1'b1, rd: push1_rd, wd: push1_wd};
            if (push1)      wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
            else if (push0) wr_ptr <= ptr_inc(wr_ptr);
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].we && mem[i].rd == lk_addr_a) match_a = 1'b1;
            if (mem[i].we && mem[i].rd == lk_addr_b) match_b = 1'b1;
        end
    end
endmodule

// File: rtl/wb_write_arbiter.sv
// Merges two write-back lanes onto one register-file write port, queueing the overflow in order.
module wb_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH    = wb_arb_pkg::DEPTH,
    parameter int STALL_TH = DEPTH - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              we1,
    input  logic [REG_AW-1:0] rd1,
    input  logic [XLEN-1:0]   wd1,
    input  logic              we2,
    input  logic [REG_AW-1:0] rd2,
    input  logic [XLEN-1:0]   wd2,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              stall,
    input  logic [REG_AW-1:0] lk_addr_a,
    input  logic [REG_AW-1:0] lk_addr_b,
    output logic              lk_pend_a,
    output logic              lk_pend_b,
    output logic              overflow_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] STALL_C  = CW'(STALL_TH);

    // in_valid is a one-cycle strobe with no ready: each asserted cycle presents both lanes
    // exactly once, and the producer must keep in_valid low while stall is high.

    logic          c1, c2, deq, push0, push1, ovf_now, match_a, match_b;
    logic [CW-1:0] count, cnt_after;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0]   head_wd;
    wr_req_t       lane1, lane2, head, port_req, q0, q1;

    assign c2    = in_valid & we2 & (rd2 != '0);
    assign c1    = in_valid & we1 & (rd1 != '0) & ~(we2 & (rd2 == rd1));
    assign lane1 = '{we: c1, rd: rd1, wd: wd1};
    assign lane2 = '{we: c2, rd: rd2, wd: wd2};
    assign deq   = (count != '0);
    assign head  = '{we: deq, rd: head_rd, wd: head_wd};

    // Program order is head, L1, L2: the first live one takes the port, the rest queue.
    always_comb begin
        port_req = head;
        q0       = '0;
        q1       = '0;
        if (deq) begin
            q0 = c1 ? lane1 : lane2;
            q1 = (c1 & c2) ? lane2 : '0;
        end else begin
            port_req = c1 ? lane1 : lane2;
            q0       = (c1 & c2) ? lane2 : '0;
        end
    end

    // Youngest requests are the ones dropped when the queue cannot hold them.
    assign cnt_after = count - CW'(deq);
    assign push0     = q0.we & (cnt_after < DEPTH_C);
    assign push1     = q1.we & (cnt_after < DEPTH_M1);
    assign ovf_now   = (q0.we & ~push0) | (q1.we & ~push1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            overflow_err <= 1'b0;
        end else begin
            rf_we <= port_req.we;
            if (port_req.we) begin
                rf_waddr <= port_req.rd;
                rf_wdata <= port_req.wd;
            end
            if (ovf_now) overflow_err <= 1'b1;
        end
    end

    wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .pop       (deq),
        .push0     (push0),
        .push0_rd  (q0.rd),
        .push0_wd  (q0.wd),
        .push1     (push1),
        .push1_rd  (q1.rd),
        .push1_wd  (q1.wd),
        .head_rd   (head_rd),
        .head_wd   (head_wd),
        .count     (count),
        .lk_addr_a (lk_addr_a),
        .lk_addr_b (lk_addr_b),
        .match_a   (match_a),
        .match_b   (match_b)
    );

    assign stall     = (count >= STALL_C);
    assign lk_pend_a = (lk_addr_a != '0) & (match_a | (rf_we & (rf_waddr == lk_addr_a)));
    assign lk_pend_b = (lk_addr_b != '0) & (match_b | (rf_we & (rf_waddr == lk_addr_b)));
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed scenarios plus random traffic against a list-based model of the pending writes.
module tb_wb_write_arbiter;
  localparam int DEPTH    = 4;
  localparam int STALL_TH = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, we1, we2;
  logic [4:0]  rd1, rd2, lk_addr_a, lk_addr_b;
  logic [31:0] wd1, wd2;
  logic        rf_we, stall, lk_pend_a, lk_pend_b, overflow_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  wb_write_arbiter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .we1(we1), .rd1(rd1), .wd1(wd1), .we2(we2), .rd2(rd2), .wd2(wd2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall(stall),
    .lk_addr_a(lk_addr_a), .lk_addr_b(lk_addr_b),
    .lk_pend_a(lk_pend_a), .lk_pend_b(lk_pend_b), .overflow_err(overflow_err)
  );

  // Model: pending writes as {rd, wd} in program order, plus the last port write.
  logic [36:0] exp_q[$];
  logic        m_we, m_ovf;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic model_pend(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (m_we && m_waddr == a) return 1'b1;
    foreach (exp_q[i]) if (exp_q[i][36:32] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_we = 1'b0; m_ovf = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic model_edge();
    logic [36:0] lst[$];
    logic [36:0] w;
    lst = exp_q;
    if (in_valid && we1 && rd1 != 0 && !(we2 && rd2 == rd1)) lst.push_back({rd1, wd1});
    if (in_valid && we2 && rd2 != 0) lst.push_back({rd2, wd2});
    if (lst.size() > 0) begin
      w = lst.pop_front();
      m_we = 1'b1; m_waddr = w[36:32]; m_wdata = w[31:0];
    end else begin
      m_we = 1'b0;
    end
    if (lst.size() > DEPTH) begin
      m_ovf = 1'b1;
      while (lst.size() > DEPTH) void'(lst.pop_back());
    end
    exp_q = lst;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rf_we"},    32'(rf_we),        32'(m_we));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr),     32'(m_waddr));
    chk({tag, ".rf_wdata"}, rf_wdata,          m_wdata);
    chk({tag, ".stall"},    32'(stall),        32'(exp_q.size() >= STALL_TH));
    chk({tag, ".ovf"},      32'(overflow_err), 32'(m_ovf));
    chk({tag, ".pend_a"},   32'(lk_pend_a),    32'(model_pend(lk_addr_a)));
    chk({tag, ".pend_b"},   32'(lk_pend_b),    32'(model_pend(lk_addr_b)));
  endtask

  task automatic step(input string tag, input logic iv,
                      input logic w1, input logic [4:0] r1, input logic [31:0] d1,
                      input logic w2, input logic [4:0] r2, input logic [31:0] d2);
    in_valid = iv; we1 = w1; rd1 = r1; wd1 = d1; we2 = w2; rd2 = r2; wd2 = d2;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic dual(input string tag, input logic [4:0] base);
    step(tag, 1'b1, 1'b1, base, 32'(base) + 32'h100, 1'b1, base + 5'd1, 32'(base) + 32'h200);
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; we1 = 0; we2 = 0; rd1 = 0; rd2 = 0; wd1 = 0; wd2 = 0;
    lk_addr_a = 0; lk_addr_b = 0;
    model_clear();
    #12;
    check_all("reset");
    @(posedge clk); #2 reset = 1'b0;

    // Split dual write with a lookup that stays pending until the younger write retires.
    lk_addr_a = 5'd4; lk_addr_b = 5'd3;
    step("split0", 1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    chk("split0.addr", 32'(rf_waddr), 32'd3);
    chk("split0.pend4", 32'(lk_pend_a), 32'd1);
    idle("split1", 1);
    chk("split1.data", rf_wdata, 32'h22);
    chk("split1.pend4", 32'(lk_pend_a), 32'd1);
    idle("split2", 1);
    chk("split2.pend4", 32'(lk_pend_a), 32'd0);

    // Same-destination pair coalesces to the younger write.
    lk_addr_a = 5'd5;
    step("waw", 1'b1, 1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB);
    chk("waw.data", rf_wdata, 32'hB);
    chk("waw.stall", 32'(stall), 32'd0);
    idle("waw_idle", 2);

    // Fill to the threshold, then drain.
    lk_addr_a = 5'd12; lk_addr_b = 5'd7;
    dual("fill0", 5'd6); dual("fill1", 5'd8); dual("fill2", 5'd10);
    chk("fill.stall", 32'(stall), 32'd1);
    idle("drain0", 1);
    chk("drain0.stall", 32'(stall), 32'd0);
    idle("drain", 4);

    // Ignore stall until the queue overflows; the flag must be sticky.
    dual("ovf0", 5'd1); dual("ovf1", 5'd3); dual("ovf2", 5'd5); dual("ovf3", 5'd7);
    dual("ovf4", 5'd9);
    chk("ovf4.flag", 32'(overflow_err), 32'd1);
    idle("ovf_drain", 6);
    chk("ovf_hold", 32'(overflow_err), 32'd1);

    // x0 writes are dropped.
    lk_addr_a = 5'd0;
    step("x0", 1'b1, 1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'h6);
    chk("x0.we", 32'(rf_we), 32'd0);
    chk("x0.pend", 32'(lk_pend_a), 32'd0);

    // Asynchronous reset with writes queued.
    lk_addr_a = 5'd20; lk_addr_b = 5'd23;
    dual("pre_rst0", 5'd20); dual("pre_rst1", 5'd22); dual("pre_rst2", 5'd24);
    in_valid = 1'b0; we1 = 1'b0; we2 = 1'b0;
    #2 reset = 1'b1;
    #1 model_clear();
    check_all("async_rst");
    @(posedge clk); #1 check_all("rst_hold");
    #2 reset = 1'b0;
    idle("post_rst", 4);

    for (int i = 0; i < 400; i++) begin
      lk_addr_a = 5'($urandom_range(0, 7));
      lk_addr_b = 5'($urandom_range(0, 7));
      step("rand", ($urandom_range(0, 3) != 0) && (exp_q.size() < STALL_TH),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end
    idle("rand_drain", 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
